// File: rtl/cam_pkg.sv
// Shared types and helpers for the hashtable write-side engine.
package cam_pkg;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_INSERT = 2'b01,
      OP_DELETE = 2'b10,
      OP_RSVD   = 2'b11
   } cam_op_e;

   typedef enum logic [1:0] {
      ST_OK        = 2'b00,
      ST_UPDATED   = 2'b01,
      ST_COLLISION = 2'b10,
      ST_NOT_FOUND = 2'b11
   } cam_status_e;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_READ,
      S_COMMIT,
      S_RESP
   } cam_upd_state_e;

   localparam int unsigned CAM_KEY_W  = 8;
   localparam int unsigned CAM_DATA_W = 4;
   localparam int unsigned CAM_FOLD_W = 64;

   typedef struct packed {
      logic                  valid;
      logic [CAM_KEY_W-1:0]  key;
      logic [CAM_DATA_W-1:0] data;
   } cam_entry_t;

   // XOR-fold of a zero-extended key into aw-bit slices; bits above aw stay 0.
   function automatic logic [31:0] cam_index(input logic [CAM_FOLD_W-1:0] key,
                                             input int unsigned aw);
      logic [31:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < CAM_FOLD_W; i++) begin
         idx[5'(i % aw)] = idx[5'(i % aw)] ^ key[6'(i)];
      end
      return idx;
   endfunction

endpackage

// File: rtl/cam_update_engine.sv
// Hashtable write engine: post-reset table clear, then read-check-write per
// insert/delete request, with a same-cycle forward stream for lookup correction.
module cam_update_engine
   import cam_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 4,
   parameter  int unsigned KEY_WIDTH  = 8,
   parameter  int unsigned ADDR_WIDTH = 4,
   localparam int unsigned ENTRY_W    = 1 + KEY_WIDTH + DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [1:0]            req_op_i,
   input  logic [KEY_WIDTH-1:0]  req_key_i,
   input  logic [DATA_WIDTH-1:0] req_data_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [1:0]            resp_status_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_rd_en_o,
   output logic                  mem_wr_en_o,
   output logic [ENTRY_W-1:0]    mem_wdata_o,
   input  logic [ENTRY_W-1:0]    mem_rdata_i,
   output logic [KEY_WIDTH-1:0]  forward_key_o,
   output logic [DATA_WIDTH-1:0] forward_data_o,
   output logic                  forward_write_o,
   output logic                  forward_del_o,
   output logic                  init_done_o
);

   typedef struct packed {
      logic                  valid;
      logic [KEY_WIDTH-1:0]  key;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   cam_upd_state_e        state;
   logic [ADDR_WIDTH-1:0] cnt;
   cam_op_e               op_q;
   logic [KEY_WIDTH-1:0]  key_q;
   logic [DATA_WIDTH-1:0] data_q;

   entry_t                rd_entry;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  mem_en;
   logic                  hit;
   logic                  do_ins;
   logic                  do_del;
   cam_status_e           commit_status;

   assign rd_entry = mem_rdata_i;
   assign idx      = ADDR_WIDTH'(cam_index(64'(key_q), ADDR_WIDTH));
   // RAM strobes are suppressed while stalled or while reset is being applied.
   assign mem_en   = clk_en & ~reset;
   assign hit      = rd_entry.valid && (rd_entry.key == key_q);
   assign do_ins   = (op_q == OP_INSERT) && (!rd_entry.valid || hit);
   assign do_del   = (op_q == OP_DELETE) && hit;

   // Status of the read-check-write, decided from the RAM word seen in COMMIT.
   always_comb begin
      commit_status = ST_NOT_FOUND;
      if (op_q == OP_INSERT) begin
         if (!rd_entry.valid)  commit_status = ST_OK;
         else if (hit)         commit_status = ST_UPDATED;
         else                  commit_status = ST_COLLISION;
      end else if (hit) begin
         commit_status = ST_OK;
      end
   end

   // RAM port and forward stream; COMMIT depends on the just-returned read data.
   always_comb begin
      mem_addr_o      = '0;
      mem_rd_en_o     = 1'b0;
      mem_wr_en_o     = 1'b0;
      mem_wdata_o     = '0;
      forward_key_o   = '0;
      forward_data_o  = '0;
      forward_write_o = 1'b0;
      forward_del_o   = 1'b0;
      case (state)
         S_INIT: begin
            mem_addr_o  = cnt;
            mem_wr_en_o = mem_en;
         end
         S_READ: begin
            mem_addr_o  = idx;
            mem_rd_en_o = mem_en;
         end
         S_COMMIT: begin
            mem_addr_o = idx;
            if (do_ins) begin
               mem_wr_en_o     = mem_en;
               mem_wdata_o     = {1'b1, key_q, data_q};
               forward_key_o   = key_q;
               forward_data_o  = data_q;
               forward_write_o = 1'b1;
            end else if (do_del) begin
               mem_wr_en_o   = mem_en;
               forward_key_o = key_q;
               forward_del_o = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_INIT;
         cnt           <= '0;
         op_q          <= OP_NOP;
         key_q         <= '0;
         data_q        <= '0;
         req_ready_o   <= 1'b0;
         resp_valid_o  <= 1'b0;
         resp_status_o <= ST_OK;
         init_done_o   <= 1'b0;
      end else if (clk_en) begin
         case (state)
            S_INIT: begin
               cnt <= cnt + ADDR_WIDTH'(1);
               if (cnt == '1) begin
                  state       <= S_IDLE;
                  init_done_o <= 1'b1;
                  req_ready_o <= 1'b1;
               end
            end
            S_IDLE: begin
               if (req_valid_i) begin
                  op_q        <= cam_op_e'(req_op_i);
                  key_q       <= req_key_i;
                  data_q      <= req_data_i;
                  req_ready_o <= 1'b0;
                  if (req_op_i == OP_INSERT || req_op_i == OP_DELETE) begin
                     state <= S_READ;
                  end else begin
                     state         <= S_RESP;
                     resp_valid_o  <= 1'b1;
                     resp_status_o <= ST_OK;
                  end
               end
            end
            S_READ: state <= S_COMMIT;
            S_COMMIT: begin
               state         <= S_RESP;
               resp_valid_o  <= 1'b1;
               resp_status_o <= commit_status;
            end
            S_RESP: begin
               if (resp_ready_i) begin
                  state        <= S_IDLE;
                  resp_valid_o <= 1'b0;
                  req_ready_o  <= 1'b1;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: doc/cam_update_engine.md
# cam_update_engine

Write-side engine of the hashtable: accepts insert/delete requests over a valid/ready handshake, performs a read-check-write on the external single-port table RAM, and returns a status. In every commit cycle it drives the forward stream (`forward_key/data/write/del`), which the lookup-path correction stage consumes to patch lookups that read the RAM one cycle too early. It also clears the table after reset.

## Interface
- `DATA_WIDTH`, 4: payload width.
- `KEY_WIDTH`, 8: key width. Must be ≥ `ADDR_WIDTH`.
- `ADDR_WIDTH`, 4: table index width; table depth is 2^`ADDR_WIDTH`.
- `ENTRY_W` (localparam) = 1+`KEY_WIDTH`+`DATA_WIDTH`. Entry layout: {valid, key, data}, with data in the LSBs.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  synchronous, active-high.
- `clk_en`  in  1  global enable. When low, all state freezes, and `mem_rd_en_o`/`mem_wr_en_o` are forced to 0.
- `req_valid_i` in 1, `req_ready_o` out 1: request handshake.
- `req_op_i`  in  2  operation: 00 NOP, 01 INSERT, 10 DELETE, 11 reserved (treated as NOP).
- `req_key_i`  in  KEY_WIDTH;  `req_data_i`  in  DATA_WIDTH.
- `resp_valid_o` out 1, `resp_ready_i` in 1: response handshake.
- `resp_status_o`  out  2  response status: 00 OK, 01 UPDATED, 10 COLLISION, 11 NOT_FOUND.
- `mem_addr_o` out ADDR_WIDTH; `mem_rd_en_o` out 1; `mem_wr_en_o` out 1; `mem_wdata_o` out ENTRY_W.
- `mem_rdata_i`  in  ENTRY_W  RAM read data, valid one cycle after `mem_rd_en_o`.
- `forward_key_o` out KEY_WIDTH; `forward_data_o` out DATA_WIDTH; `forward_write_o` out 1; `forward_del_o` out 1.
- `init_done_o`  out  1  goes high when the clear sweep finishes and stays high until the next reset.

## Operation
- Index computation: `idx` = XOR of all `ADDR_WIDTH`-wide slices of the key. The top slice is zero-padded.
- FSM states: INIT, IDLE, READ, COMMIT, RESP.
- INIT:
  - Entered on reset.
  - Counter `cnt` starts at 0.
  - Each enabled cycle: `mem_wr_en_o`=1, `mem_addr_o`=`cnt`, `mem_wdata_o`=0, then `cnt` increments.
  - After writing address 2^`ADDR_WIDTH`-1, the FSM moves to IDLE and `init_done_o` is set.
  - `forward_*` stay 0 throughout.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i`&`req_ready_o`, latch op/key/data.
  - INSERT or DELETE goes to READ.
  - NOP or reserved goes directly to RESP with status OK. No memory access.
- READ: `mem_rd_en_o`=1, `mem_addr_o`=`idx`. Next state is COMMIT.
- COMMIT: examine `mem_rdata_i` (fields `v`, `k`) and act as follows. Next state is RESP.
  - INSERT, `v`=0: write {1,key,data}. Status OK.
  - INSERT, `v`=1 and `k`==key: write {1,key,data}. Status UPDATED.
  - INSERT, `v`=1 and `k`!=key: no write. Status COLLISION.
  - DELETE, `v`=1 and `k`==key: write all-zero entry. Status OK.
  - DELETE, any other case: no write. Status NOT_FOUND.
  - Whenever a write happens: `mem_addr_o`=`idx`, `mem_wr_en_o`=1, `forward_key_o`=key.
    - Insert: `forward_write_o`=1, `forward_data_o`=data.
    - Delete: `forward_del_o`=1, `forward_data_o`=0.
  - `forward_write_o` and `forward_del_o` are never both 1.
- RESP: `resp_valid_o`=1 with `resp_status_o` registered. The FSM holds until `resp_ready_i`, then goes to IDLE.

## Timing
- Values after reset: state INIT, `cnt`=0, `init_done_o`=0, `req_ready_o`=0, `resp_valid_o`=0, `resp_status_o`=00, all `mem_*` outputs 0, all `forward_*` outputs 0.
- The INIT sweep takes exactly 2^`ADDR_WIDTH` enabled cycles. `req_ready_o` rises in the following cycle.
- INSERT/DELETE latency: accept in cycle T, READ in T+1, COMMIT in T+2, `resp_valid_o` in T+3. NOP gives `resp_valid_o` in T+1.
- Throughput: at most one operation per 4 cycles. `req_ready_o` is high only in IDLE.
- Forward stream:
  - `forward_*` are driven from the latched request and `mem_rdata_i`, and are valid only during the single COMMIT cycle, the same cycle as `mem_wr_en_o`.
  - Outside COMMIT, `forward_write_o` and `forward_del_o` are 0.
- Response handshake: `resp_valid_o` and `resp_status_o` stay stable until `resp_ready_i`. No new request is accepted while a response is pending.
- `clk_en` low:
  - The FSM, counter and latched request freeze.
  - Memory enables are forced low.
  - `resp_valid_o` and `forward_*` hold their values.
  - The stalled cycle does not count toward latency.
- Reset in any state: back to INIT in the next cycle. Any pending request or response is dropped and no response is ever issued for it.

## Structure
- Shared package `cam_pkg`:
  - enums `cam_op_e` and `cam_status_e`;
  - FSM enum `cam_upd_state_e`;
  - parameterized entry struct (valid/key/data);
  - function `cam_index(key)` implementing the XOR fold.
- No sub-module. A single FSM module with the request latch and INIT counter is sufficient.

## Test plan
All scenarios use KEY=8, ADDR=4, DATA=4. `idx(0x3A)`=9 and `idx(0x5C)`=9.
- Reset, hold 20 cycles → 16 writes to addr 0..15 with `mem_wdata_o`=0; `req_ready_o` and `init_done_o` rise in cycle 17.
- INSERT 0x3A/0x7 into the cleared table → READ addr 9; COMMIT writes {1,0x3A,0x7}; forward key 0x3A, data 0x7, write=1, del=0; status OK at T+3.
- INSERT 0x3A/0x2 again → UPDATED; forward data 0x2. Then INSERT 0x5C/0x1 → COLLISION, `mem_wr_en_o`=0, `forward_write_o`=0.
- DELETE 0x5C → NOT_FOUND, no write. DELETE 0x3A → writes 0 to addr 9; `forward_del_o`=1, key 0x3A, data 0; status OK.
- Hold `resp_ready_i` low for 5 cycles → `resp_valid_o` and status stable, `req_ready_o`=0. Toggle `clk_en` low for 3 cycles mid-READ → latency extends by exactly 3.
- Assert `reset` during COMMIT → next cycle INIT, no `resp_valid_o` for that request, the full sweep repeats.
